// File: rtl/port_uart_tx.sv
// port_uart_tx: port-mapped 8N1 UART transmitter with toggle handshake and sticky overrun
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_out_data,
  input  logic [7:0] port_out_ctrl,
  output logic [7:0] port_in_status,
  output logic       tx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic req_prev_q, busy_q, busy_d, ack_q, ack_d, ovr_q, ovr_d, tx_q, tx_d;
  logic req_edge, accept, wrap;
  logic unused_ctrl;
  assign unused_ctrl = ^port_out_ctrl[7:2];
  always_comb begin
    req_edge = port_out_ctrl[0] ^ req_prev_q;
    accept = req_edge && state_q == IDLE;
    wrap = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    if (accept) begin
      state_d = START;
      shift_d = port_out_data;
    end else if (wrap && state_q != IDLE) begin
      state_d = state_q == START ? DATA : state_q == STOP ? IDLE : idx_q == 3'd7 ? STOP : DATA;
      idx_d = state_q == DATA ? idx_q + 3'd1 : 3'd0;
      shift_d = state_q == DATA ? shift_q >> 1 : shift_q;
    end
    ack_d = ack_q ^ accept;
    ovr_d = (req_edge && state_q != IDLE) || (ovr_q && !port_out_ctrl[1]);
    busy_d = state_d != IDLE;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      req_prev_q <= port_out_ctrl[0];
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      ovr_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      req_prev_q <= port_out_ctrl[0];
      busy_q <= busy_d;
      ack_q <= ack_d;
      ovr_q <= ovr_d;
      tx_q <= tx_d;
    end
  end
  assign port_in_status = {5'b0, ovr_q, ack_q, busy_q};
  assign tx = tx_q;
endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: scoreboard bench for the port-mapped UART transmitter
module tb_port_uart_tx;
  localparam int C = 4;
  typedef struct {logic [7:0] d; int t;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pd = 8'h00;
  logic [7:0] pc = 8'h00;
  logic [7:0] st;
  logic tx;
  int cyc = 0;
  int pass_n = 0;
  int tot_n = 0;
  logic exp_ack = 1'b0;
  exp_t q[$];
  port_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .port_out_data(pd), .port_out_ctrl(pc),
    .port_in_status(st), .tx(tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [39:0] frame_of(logic [7:0] d);
    logic [39:0] f;
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < C; j++)
        f[b*C+j] = b == 0 ? 1'b0 : b == 9 ? 1'b1 : d[b-1];
    return f;
  endfunction
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic toggle(logic [7:0] d, bit acc);
    pd = d;
    pc[0] = ~pc[0];
    if (acc) begin
      q.push_back('{d, cyc + 1});
      exp_ack = ~exp_ack;
    end
    tick(1);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (st[0] !== 1'b0 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) chk("busy_timeout", 1, 0);
  endtask
  initial begin : monitor
    logic pv;
    logic ab;
    logic bh;
    int t0;
    logic [39:0] s;
    exp_t e;
    pv = 1'b1;
    forever begin
      @(negedge clk);
      if (pv === 1'b1 && tx === 1'b0 && !reset) begin
        t0 = cyc;
        ab = 1'b0;
        bh = 1'b1;
        for (int i = 0; i < 10*C; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) ab = 1'b1;
          s[i] = tx;
          if (st[0] !== 1'b1) bh = 1'b0;
        end
        if (!ab) begin
          @(negedge clk);
          chk("busy_fall", {39'b0, st[0]}, 40'd0);
          if (q.size() == 0) chk("unexpected_frame", 40'd1, 40'd0);
          else begin
            e = q.pop_front();
            chk("frame_bits", s, frame_of(e.d));
            chk("start_latency", 40'(t0), 40'(e.t));
            chk("busy_during_frame", {39'b0, bh}, 40'd1);
          end
        end
        pv = tx;
      end else pv = tx;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    tick(2);
    chk("reset_tx", {39'b0, tx}, 40'd1);
    chk("reset_status", {32'b0, st}, 40'h00);
    reset = 1'b0;
    tick(2);
    toggle(8'hA5, 1);
    chk("t1_status_busy", {32'b0, st}, 40'h03);
    wait_idle();
    chk("t1_status_after", {32'b0, st}, 40'h02);
    tick(5);
    pc[0] = 1'b1;
    reset = 1'b1;
    exp_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t2_tx_idle", {39'b0, tx}, 40'd1);
    chk("t2_status_idle", {32'b0, st}, 40'h00);
    toggle(8'h00, 1);
    wait_idle();
    tick(3);
    toggle(8'h3C, 1);
    tick(9);
    toggle(8'hFF, 0);
    chk("t3_ovr_set", {39'b0, st[2]}, 40'd1);
    wait_idle();
    chk("t3_status_after", {32'b0, st}, {37'b0, 1'b1, exp_ack, 1'b0});
    pc[1] = 1'b1;
    tick(1);
    pc[1] = 1'b0;
    chk("t3_ovr_clear", {39'b0, st[2]}, 40'd0);
    tick(3);
    toggle(8'h81, 1);
    wait_idle();
    toggle(8'h6E, 1);
    chk("t4_ack_b2b", {39'b0, st[1]}, {39'b0, exp_ack});
    wait_idle();
    tick(3);
    toggle(8'h55, 0);
    tick(14);
    reset = 1'b1;
    tick(1);
    chk("t5_tx_after_reset", {39'b0, tx}, 40'd1);
    chk("t5_status_after_reset", {32'b0, st}, 40'h00);
    reset = 1'b0;
    exp_ack = 1'b0;
    tick(60);
    chk("t5_no_frame_tx", {39'b0, tx}, 40'd1);
    chk("t5_no_frame_status", {32'b0, st}, 40'h00);
    toggle(8'h5A, 1);
    tick(5);
    pc[1] = 1'b1;
    toggle(8'h00, 0);
    pc[1] = 1'b0;
    tick(1);
    chk("t6_set_wins", {39'b0, st[2]}, 40'd1);
    wait_idle();
    chk("t6_status_after", {32'b0, st}, {37'b0, 1'b1, exp_ack, 1'b0});
    tick(60);
    chk("queue_drained", 40'(q.size()), 40'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
